// File: rtl/y86_pkg.sv
// Shared constants for the Y86-64 SEQ execute stage: instruction codes,
// ALU function selects and branch/cmov condition codes.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] I_IADDQ  = 4'hC;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_XOR = 2'd3;

    localparam logic [3:0] C_ALWAYS = 4'd0;
    localparam logic [3:0] C_LE     = 4'd1;
    localparam logic [3:0] C_L      = 4'd2;
    localparam logic [3:0] C_E      = 4'd3;
    localparam logic [3:0] C_NE     = 4'd4;
    localparam logic [3:0] C_GE     = 4'd5;
    localparam logic [3:0] C_G      = 4'd6;

    // OPq function codes above XOR are not defined by the ISA.
    function automatic logic opq_fn_valid(input logic [3:0] fn);
        return fn < 4'd4;
    endfunction

endpackage

// File: rtl/y86_alu.sv
// Combinational Y86 ALU: result = aluB op aluA, plus zero/sign/overflow flags.
module y86_alu
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [W-1:0] aluA,
    input  logic [W-1:0] aluB,
    input  logic [1:0]   alu_fn,
    output logic [W-1:0] result,
    output logic         zf,
    output logic         sf,
    output logic         of
);

    always_comb begin
        result = '0;
        of     = 1'b0;
        case (alu_fn)
            ALU_ADD: begin
                result = aluB + aluA;
                of     = (aluA[W-1] == aluB[W-1]) && (result[W-1] != aluB[W-1]);
            end
            ALU_SUB: begin
                result = aluB - aluA;
                of     = (aluB[W-1] != aluA[W-1]) && (result[W-1] != aluB[W-1]);
            end
            ALU_AND: result = aluB & aluA;
            ALU_XOR: result = aluB ^ aluA;
            default: begin
                result = '0;
                of     = 1'b0;
            end
        endcase
    end

    assign zf = (result == '0);
    assign sf = result[W-1];

endmodule

// File: rtl/y86_execute_stage.sv
// Y86-64 SEQ execute stage: operand muxing, ALU, condition-code register and
// cmov/jump condition. Define EXECUTE_IADDQ_EN to enable the iaddq instruction.
module y86_execute_stage
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   icode,
    input  logic [3:0]   ifun,
    input  logic [W-1:0] valA,
    input  logic [W-1:0] valB,
    input  logic [W-1:0] valC,
    output logic [W-1:0] valE,
    output logic         Cnd,
    output logic         ZF,
    output logic         SF,
    output logic         OF,
    output logic [1:0]   alu_fn
);

    localparam logic [W-1:0] STACK_STEP = W'(8);
    localparam logic [W-1:0] STACK_DOWN = '0 - STACK_STEP;

    logic [W-1:0] aluA;
    logic [W-1:0] aluB;
    logic [1:0]   fn_sel;
    logic         set_cc;
    logic [W-1:0] alu_result;
    logic         new_zf;
    logic         new_sf;
    logic         new_of;
    logic         cond_ok;

    // Unused operands stay zero so that an add yields valE=0 for
    // halt/nop/jXX and any undefined instruction.
    always_comb begin
        aluA   = '0;
        aluB   = '0;
        fn_sel = ALU_ADD;
        set_cc = 1'b0;
        case (icode)
            I_CMOVXX: aluA = valA;
            I_IRMOVQ: aluA = valC;
            I_RMMOVQ, I_MRMOVQ: begin
                aluA = valC;
                aluB = valB;
            end
            I_OPQ: begin
                if (opq_fn_valid(ifun)) begin
                    aluA   = valA;
                    aluB   = valB;
                    fn_sel = ifun[1:0];
                    set_cc = 1'b1;
                end
            end
            I_CALL, I_PUSHQ: begin
                aluA = STACK_DOWN;
                aluB = valB;
            end
            I_RET, I_POPQ: begin
                aluA = STACK_STEP;
                aluB = valB;
            end
`ifdef EXECUTE_IADDQ_EN
            I_IADDQ: begin
                aluA   = valC;
                aluB   = valB;
                set_cc = 1'b1;
            end
`else
            I_IADDQ: begin
                aluA = '0;
                aluB = '0;
            end
`endif
            default: begin
                aluA = '0;
                aluB = '0;
            end
        endcase
    end

    y86_alu #(.W(W)) u_alu (
        .aluA   (aluA),
        .aluB   (aluB),
        .alu_fn (fn_sel),
        .result (alu_result),
        .zf     (new_zf),
        .sf     (new_sf),
        .of     (new_of)
    );

    assign valE   = alu_result;
    assign alu_fn = fn_sel;

    // Reset takes priority over a flag-setting instruction on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ZF <= 1'b1;
            SF <= 1'b0;
            OF <= 1'b0;
        end else if (set_cc) begin
            ZF <= new_zf;
            SF <= new_sf;
            OF <= new_of;
        end
    end

    // Conditions read the registered flags, not this cycle's ALU flags.
    always_comb begin
        cond_ok = 1'b0;
        case (ifun)
            C_ALWAYS: cond_ok = 1'b1;
            C_LE:     cond_ok = (SF ^ OF) | ZF;
            C_L:      cond_ok = SF ^ OF;
            C_E:      cond_ok = ZF;
            C_NE:     cond_ok = !ZF;
            C_GE:     cond_ok = !(SF ^ OF);
            C_G:      cond_ok = !(SF ^ OF) & !ZF;
            default:  cond_ok = 1'b0;
        endcase
    end

    assign Cnd = ((icode == I_CMOVXX) || (icode == I_JXX)) && cond_ok;

endmodule

// File: tb/tb_y86_execute_stage.sv
// Directed self-checking bench for y86_execute_stage; iaddq checks follow
// whether EXECUTE_IADDQ_EN is defined.
module tb_y86_execute_stage;

    logic        clk;
    logic        rst;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic [63:0] valE;
    logic        Cnd;
    logic        ZF;
    logic        SF;
    logic        OF;
    logic [1:0]  alu_fn;

    int errors = 0;
    int checks = 0;

    y86_execute_stage #(.W(64)) dut (
        .clk    (clk),
        .rst    (rst),
        .icode  (icode),
        .ifun   (ifun),
        .valA   (valA),
        .valB   (valB),
        .valC   (valC),
        .valE   (valE),
        .Cnd    (Cnd),
        .ZF     (ZF),
        .SF     (SF),
        .OF     (OF),
        .alu_fn (alu_fn)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] ic, input logic [3:0] fn,
                                 input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        icode = ic;
        ifun  = fn;
        valA  = a;
        valB  = b;
        valC  = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkFlags(input string tag, input logic z, input logic s, input logic o);
        checkOutput({tag, ".ZF"}, {63'd0, ZF}, {63'd0, z});
        checkOutput({tag, ".SF"}, {63'd0, SF}, {63'd0, s});
        checkOutput({tag, ".OF"}, {63'd0, OF}, {63'd0, o});
    endtask

    task automatic checkCnd(input string tag, input logic [3:0] ic, input logic [3:0] fn, input logic exp);
        applyStimulus(ic, fn, 64'd0, 64'd0, 64'd0);
        checkOutput(tag, {63'd0, Cnd}, {63'd0, exp});
    endtask

    // Non-CC instruction: check valE, alu_fn=add, and that flags hold over an edge.
    task automatic checkNoCc(input string tag, input logic [3:0] ic,
                             input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                             input logic [63:0] expE, input logic z, input logic s, input logic o);
        applyStimulus(ic, 4'd0, a, b, c);
        checkOutput({tag, ".valE"}, valE, expE);
        checkOutput({tag, ".alu_fn"}, {62'd0, alu_fn}, 64'd0);
        tick();
        checkFlags(tag, z, s, o);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(4'h1, 4'h0, 64'd0, 64'd0, 64'd0);
        tick();
        tick();
        rst = 1'b0;
        applyStimulus(4'h1, 4'h0, 64'd0, 64'd0, 64'd0);
        checkFlags("reset", 1'b1, 1'b0, 1'b0);
        checkOutput("nop.valE", valE, 64'd0);
        checkCnd("je_after_reset", 4'h7, 4'd3, 1'b1);
        checkCnd("jne_after_reset", 4'h7, 4'd4, 1'b0);
        checkCnd("jmp_always", 4'h7, 4'd0, 1'b1);
        checkCnd("mrmovq_cnd", 4'h5, 4'd0, 1'b0);
        checkCnd("j_ifun7", 4'h7, 4'd7, 1'b0);

        // subq: -15 - 10 = -25
        applyStimulus(4'h6, 4'd1, 64'd10, 64'hFFFF_FFFF_FFFF_FFF1, 64'd0);
        checkOutput("sub.valE", valE, 64'hFFFF_FFFF_FFFF_FFE7);
        checkOutput("sub.alu_fn", {62'd0, alu_fn}, 64'd1);
        checkFlags("sub.before_edge", 1'b1, 1'b0, 1'b0);
        tick();
        checkFlags("sub", 1'b0, 1'b1, 1'b0);
        checkCnd("sub.jle", 4'h7, 4'd1, 1'b1);
        checkCnd("sub.jge", 4'h7, 4'd5, 1'b0);

        applyStimulus(4'h6, 4'd2, 64'h18, 64'h18, 64'h1111_1111_1111_1111);
        checkOutput("and.valE", valE, 64'h18);
        checkOutput("and.alu_fn", {62'd0, alu_fn}, 64'd2);
        tick();
        checkFlags("and", 1'b0, 1'b0, 1'b0);
        checkCnd("and.jle", 4'h7, 4'd1, 1'b0);
        checkCnd("and.jg", 4'h7, 4'd6, 1'b1);
        checkCnd("and.cmovne", 4'h2, 4'd4, 1'b1);

        applyStimulus(4'h6, 4'd3, 64'hFF, 64'h0F, 64'd0);
        checkOutput("xor.valE", valE, 64'hF0);
        checkOutput("xor.alu_fn", {62'd0, alu_fn}, 64'd3);
        tick();
        checkFlags("xor", 1'b0, 1'b0, 1'b0);

        applyStimulus(4'h6, 4'd1, 64'd7, 64'd7, 64'd0);
        checkOutput("sub_zero.valE", valE, 64'd0);
        tick();
        checkFlags("sub_zero", 1'b1, 1'b0, 1'b0);
        checkCnd("sub_zero.je", 4'h7, 4'd3, 1'b1);
        checkCnd("sub_zero.jg", 4'h7, 4'd6, 1'b0);

        // Sub overflow: minimum negative minus one.
        applyStimulus(4'h6, 4'd1, 64'd1, 64'h8000_0000_0000_0000, 64'd0);
        checkOutput("sub_ovf.valE", valE, 64'h7FFF_FFFF_FFFF_FFFF);
        tick();
        checkFlags("sub_ovf", 1'b0, 1'b0, 1'b1);
        checkCnd("sub_ovf.jl", 4'h7, 4'd2, 1'b1);

        applyStimulus(4'h6, 4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
        checkOutput("add_ovf.valE", valE, 64'h8000_0000_0000_0000);
        checkOutput("add_ovf.alu_fn", {62'd0, alu_fn}, 64'd0);
        tick();
        checkFlags("add_ovf", 1'b0, 1'b1, 1'b1);
        checkCnd("add_ovf.jl", 4'h7, 4'd2, 1'b0);
        checkCnd("add_ovf.jge", 4'h7, 4'd5, 1'b1);

        // Flags are now ZF=0 SF=1 OF=1 and must hold through non-OPq work.
        checkNoCc("rmmovq", 4'h4, 64'd0, 64'h20, 64'd8, 64'h28, 1'b0, 1'b1, 1'b1);
        checkNoCc("mrmovq", 4'h5, 64'd0, 64'h40, 64'h10, 64'h50, 1'b0, 1'b1, 1'b1);
        checkNoCc("pushq", 4'hA, 64'd0, 64'h100, 64'd0, 64'hF8, 1'b0, 1'b1, 1'b1);
        checkNoCc("call", 4'h8, 64'd0, 64'h200, 64'd0, 64'h1F8, 1'b0, 1'b1, 1'b1);
        checkNoCc("popq", 4'hB, 64'd0, 64'h100, 64'd0, 64'h108, 1'b0, 1'b1, 1'b1);
        checkNoCc("ret", 4'h9, 64'd0, 64'h300, 64'd0, 64'h308, 1'b0, 1'b1, 1'b1);
        checkNoCc("irmovq", 4'h3, 64'd9, 64'd9, 64'd5, 64'd5, 1'b0, 1'b1, 1'b1);
        checkNoCc("cmovxx", 4'h2, 64'h55, 64'h77, 64'h99, 64'h55, 1'b0, 1'b1, 1'b1);
        checkNoCc("jxx", 4'h7, 64'h55, 64'h77, 64'h99, 64'd0, 1'b0, 1'b1, 1'b1);
        checkNoCc("halt", 4'h0, 64'h55, 64'h77, 64'h99, 64'd0, 1'b0, 1'b1, 1'b1);
        checkNoCc("icode_d", 4'hD, 64'h55, 64'h77, 64'h99, 64'd0, 1'b0, 1'b1, 1'b1);

        applyStimulus(4'h6, 4'd4, 64'd3, 64'd3, 64'd3);
        checkOutput("opq_bad.valE", valE, 64'd0);
        checkOutput("opq_bad.alu_fn", {62'd0, alu_fn}, 64'd0);
        tick();
        checkFlags("opq_bad", 1'b0, 1'b1, 1'b1);

        // Reset must win over a simultaneous sub that would set SF.
        rst = 1'b1;
        applyStimulus(4'h6, 4'd1, 64'd10, 64'hFFFF_FFFF_FFFF_FFF1, 64'd0);
        tick();
        rst = 1'b0;
        checkFlags("rst_vs_opq", 1'b1, 1'b0, 1'b0);

        applyStimulus(4'h6, 4'd0, 64'd1, 64'd1, 64'd0);
        checkOutput("add.valE", valE, 64'd2);
        tick();
        checkFlags("add", 1'b0, 1'b0, 1'b0);

        applyStimulus(4'hC, 4'd0, 64'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD);
        checkOutput("iaddq.alu_fn", {62'd0, alu_fn}, 64'd0);
        checkOutput("iaddq.Cnd", {63'd0, Cnd}, 64'd0);
        checkOutput("iaddq.valE", valE, 64'd0);
        tick();
`ifdef EXECUTE_IADDQ_EN
        checkFlags("iaddq", 1'b1, 1'b0, 1'b0);
        applyStimulus(4'hC, 4'd0, 64'd0, 64'd3, 64'd5);
        checkOutput("iaddq2.valE", valE, 64'd8);
        tick();
        checkFlags("iaddq2", 1'b0, 1'b0, 1'b0);
`else
        checkFlags("iaddq", 1'b0, 1'b0, 1'b0);
        applyStimulus(4'hC, 4'd0, 64'd0, 64'd3, 64'd5);
        checkOutput("iaddq2.valE", valE, 64'd0);
        tick();
        checkFlags("iaddq2", 1'b0, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
